// File: rtl/fb_pixel_writer.sv
// Frame-buffer write stage: takes raster-ordered RTU colours, writes them into the
// back half of a double-buffered RAM and swaps front/back on the next display vsync.
module fb_pixel_writer #(
  parameter int H_RES   = 160,
  parameter int V_RES   = 120,
  parameter int COLOR_W = 12,
  parameter int ADDR_W  = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       rtu_valid,
  input  logic [COLOR_W-1:0]         rtu_color,
  output logic                       rtu_ready,
  input  logic                       vsync,
  output logic [$clog2(H_RES)-1:0]   pix_x,
  output logic [$clog2(V_RES)-1:0]   pix_y,
  output logic                       fb_we,
  output logic [ADDR_W:0]            fb_addr,
  output logic [COLOR_W-1:0]         fb_wdata,
  output logic                       front_buf,
  output logic                       busy,
  output logic                       frame_done
);

  localparam int XW = $clog2(H_RES);
  localparam int YW = $clog2(V_RES);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITE     = 2'd1,
    ST_WAIT_SWAP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [XW-1:0]       pix_x_q;
  logic [YW-1:0]       pix_y_q;
  logic [ADDR_W-1:0]   lin_addr_q;
  logic                fb_we_q;
  logic [ADDR_W:0]     fb_addr_q;
  logic [COLOR_W-1:0]  fb_wdata_q;
  logic                front_buf_q;
  logic                frame_done_q;

  logic accept_s, last_x_s, last_y_s, clear_s, swap_s;

  assign accept_s = rtu_valid && rtu_ready;
  assign last_x_s = (pix_x_q == XW'(H_RES - 1));
  assign last_y_s = (pix_y_q == YW'(V_RES - 1));
  assign clear_s  = (state_q == ST_IDLE) && start;
  assign swap_s   = (state_q == ST_WAIT_SWAP) && vsync;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_WRITE;
        else       state_d = ST_IDLE;
      end
      ST_WRITE: begin
        if (accept_s && last_x_s && last_y_s) state_d = ST_WAIT_SWAP;
        else                                  state_d = ST_WRITE;
      end
      // A vsync coincident with the last accept is seen here only a cycle later, so it never counts.
      ST_WAIT_SWAP: begin
        if (vsync) state_d = ST_IDLE;
        else       state_d = ST_WAIT_SWAP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rtu_ready = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_IDLE:      begin rtu_ready = 1'b0; busy = 1'b0; end
      ST_WRITE:     begin rtu_ready = 1'b1; busy = 1'b1; end
      ST_WAIT_SWAP: begin rtu_ready = 1'b0; busy = 1'b1; end
      default:      begin rtu_ready = 1'b0; busy = 1'b0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      lin_addr_q   <= '0;
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_wdata_q   <= '0;
      front_buf_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      fb_we_q      <= accept_s;
      frame_done_q <= swap_s;
      if (swap_s) front_buf_q <= ~front_buf_q;
      if (accept_s) begin
        fb_addr_q  <= {~front_buf_q, lin_addr_q};
        fb_wdata_q <= rtu_color;
      end
      // Linear address runs alongside x/y so no multiply is needed.
      if (clear_s) begin
        pix_x_q    <= '0;
        pix_y_q    <= '0;
        lin_addr_q <= '0;
      end else if (accept_s) begin
        lin_addr_q <= lin_addr_q + ADDR_W'(1);
        if (last_x_s) begin
          pix_x_q <= '0;
          pix_y_q <= last_y_s ? '0 : pix_y_q + YW'(1);
        end else begin
          pix_x_q <= pix_x_q + XW'(1);
        end
      end
    end
  end

  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign fb_we      = fb_we_q;
  assign fb_addr    = fb_addr_q;
  assign fb_wdata   = fb_wdata_q;
  assign front_buf  = front_buf_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/fb_pixel_writer.md
# fb_pixel_writer

Frame-buffer write stage that sits directly downstream of the ray-tracing unit (RTU) and under control of the frame-buffer controller. It accepts one shaded pixel colour per handshake in raster order, writes it into the back half of a double-buffered frame-buffer RAM, and tracks frame completion. It swaps front/back buffers on the next display vsync, so the scan-out never displays a partially written frame.

## Interface
Parameters:
- H_RES, 160, pixels per line
- V_RES, 120, lines per frame
- COLOR_W, 12, colour width (RGB444)
- ADDR_W, 15, per-buffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse from the controller: begin a new frame
- rtu_valid  in  1  RTU colour valid
- rtu_color  in  COLOR_W  RTU pixel colour
- rtu_ready  out  1  writer accepts a colour this cycle
- vsync  in  1  one-cycle pulse from display timing at frame boundary
- pix_x  out  $clog2(H_RES)  x of the next pixel expected
- pix_y  out  $clog2(V_RES)  y of the next pixel expected
- fb_we  out  1  frame-buffer write enable
- fb_addr  out  ADDR_W+1  {buffer select, linear address}
- fb_wdata  out  COLOR_W  write data
- front_buf  out  1  buffer currently shown by scan-out
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse when a swap completes

## Operation
- The state machine has three states: IDLE, WRITE and WAIT_SWAP.
- IDLE:
  - rtu_ready=0.
  - On start, pix_x, pix_y and the linear address counter clear to 0, and the state goes to WRITE.
- WRITE:
  - rtu_ready=1.
  - An accept occurs when rtu_valid && rtu_ready.
  - On an accept, the writer registers fb_we=1, fb_addr={~front_buf, lin_addr} and fb_wdata=rtu_color.
  - On an accept, pix_x increments. When pix_x=H_RES-1, it wraps to 0 and pix_y increments.
  - lin_addr increments by 1 per accept. No multiplier is used.
  - The accept at pix_x=H_RES-1, pix_y=V_RES-1 moves the state to WAIT_SWAP.
- WAIT_SWAP:
  - rtu_ready=0.
  - On vsync, front_buf toggles, frame_done pulses, and the state returns to IDLE.
- The back buffer is always ~front_buf. All writes go only to the back buffer.
- start is ignored outside IDLE.
- vsync is ignored outside WAIT_SWAP.
- rtu_valid is ignored while rtu_ready=0. Colour is dropped, not queued.
- Counter arithmetic is unsigned and wraps exactly at H_RES and V_RES. Coordinates never reach H_RES or V_RES.

## Timing
- Reset values:
  - state=IDLE
  - rtu_ready=0, fb_we=0, fb_addr=0, fb_wdata=0
  - pix_x=0, pix_y=0
  - front_buf=0, busy=0, frame_done=0
- rtu_ready is a combinational decode of the state. It is high in exactly the WRITE cycles.
- Write latency: a colour accepted at edge N appears on fb_we/fb_addr/fb_wdata after edge N. fb_we is high for exactly one cycle per accept.
- Back-to-back accepts produce full throughput, one write per cycle. A frame takes at least H_RES*V_RES WRITE cycles.
- pix_x/pix_y update at the accepting edge. They always show the coordinate the RTU must produce next.
- Last-pixel accept coincident with vsync: the state enters WAIT_SWAP, but that vsync is not counted. The swap waits for the next vsync.
- The frame_done pulse and the front_buf toggle occur on the same edge. busy drops on that same edge.
- start coincident with the frame_done edge is ignored, because the state is not yet IDLE.
- rst asserted mid-frame or in WAIT_SWAP returns to the reset values on the next edge. No partial swap occurs, and front_buf=0.

## Test plan
- Reset, then start with H_RES=4, V_RES=2 and rtu_valid held high with colours 0x001..0x008. Required response:
  - 8 writes to fb_addr 0x8000..0x8007 (buffer bit=1), one per cycle.
  - rtu_ready falls after the 8th accept.
- Continue that frame and pulse vsync 5 cycles later. Required response:
  - front_buf goes 0->1 and frame_done pulses for one cycle.
  - A second frame then writes fb_addr 0x0000..0x0007.
- Randomly gap rtu_valid (50%) during a frame. Required response:
  - Writes occur only on accepts, and the addresses stay contiguous.
  - pix_x/pix_y sequence is (0,0),(1,0),(2,0),(3,0),(0,1),…
- vsync pulses in IDLE, in WRITE, and in the same cycle as the last accept. Required response:
  - No swap for any of these pulses.
  - The swap occurs only on the first vsync that arrives after WAIT_SWAP is entered.
- start pulsed during WRITE and WAIT_SWAP, plus rtu_valid pulsed in IDLE. Required response: no counter reset and no fb_we.
- rst asserted after 3 accepts. Required response:
  - All outputs take their reset values on the next edge.
  - A following start begins at lin_addr 0 with buffer bit 1.
